// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller beside the decode stage. Tracks destination
// registers of in-flight instructions (EX..WB) and derives stall, kill,
// redirect and per-operand forward selects from them.
module hazard_scoreboard #(
    parameter int unsigned AW         = 5,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned LOAD_READY = 2,
    parameter int unsigned BUBBLES    = 1,
    parameter int unsigned FW         = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          id_rs_used,
    input  logic          id_rt_used,
    input  logic          id_wreg,
    input  logic [AW-1:0] id_waddr,
    input  logic          id_is_load,
    input  logic          id_redirect_req,
    input  logic          mem_wait,
    output logic          stall,
    output logic          pc_hold,
    output logic          id_kill,
    output logic          redirect,
    output logic [FW-1:0] fwda,
    output logic [FW-1:0] fwdb
);

    typedef enum logic {StRun, StRedir} state_e;

    // Stage index at which a load's data first becomes forwardable.
    localparam logic [FW-1:0] LrSel = FW'(LOAD_READY);

    state_e                    state_q, state_d;
    logic [1:0]                cnt_q, cnt_d;
    logic [DEPTH:1]            vld_q, vld_d;
    logic [DEPTH:1][AW-1:0]    waddr_q, waddr_d;
    logic [DEPTH:1]            ld_q, ld_d;

    logic          in_redir;
    logic          hit_a, hit_b, ldm_a, ldm_b;
    logic [FW-1:0] sel_a, sel_b;
    logic          use_a, use_b, lu_a, lu_b;
    logic          accept;

    assign in_redir = (state_q == StRedir);

    // Youngest-match search: scan oldest to youngest so the lowest stage wins.
    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        ldm_a = 1'b0;
        ldm_b = 1'b0;
        sel_a = '0;
        sel_b = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (vld_q[k] && (waddr_q[k] == id_rs)) begin
                hit_a = 1'b1;
                sel_a = FW'(k);
                ldm_a = ld_q[k];
            end
            if (vld_q[k] && (waddr_q[k] == id_rt)) begin
                hit_b = 1'b1;
                sel_b = FW'(k);
                ldm_b = ld_q[k];
            end
        end
    end

    // Output decode; everything is forced low while reset is held.
    always_comb begin
        use_a    = rst_n & id_valid & ~in_redir & id_rs_used & (id_rs != '0) & hit_a;
        use_b    = rst_n & id_valid & ~in_redir & id_rt_used & (id_rt != '0) & hit_b;
        lu_a     = use_a & ldm_a & (sel_a < LrSel);
        lu_b     = use_b & ldm_b & (sel_b < LrSel);
        stall    = rst_n & (mem_wait | lu_a | lu_b);
        pc_hold  = stall;
        id_kill  = rst_n & in_redir;
        redirect = rst_n & ~in_redir & id_redirect_req & id_valid & ~stall;
        fwda     = use_a ? sel_a : '0;
        fwdb     = use_b ? sel_b : '0;
        accept   = id_valid & ~in_redir & ~stall & id_wreg & (id_waddr != '0);
    end

    // Next-state: tracker shift and redirect-shadow FSM, all frozen by mem_wait.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vld_d   = vld_q;
        waddr_d = waddr_q;
        ld_d    = ld_q;
        if (!mem_wait) begin
            for (int k = DEPTH; k >= 2; k--) begin
                vld_d[k]   = vld_q[k-1];
                waddr_d[k] = waddr_q[k-1];
                ld_d[k]    = ld_q[k-1];
            end
            vld_d[1]   = accept;
            waddr_d[1] = id_waddr;
            ld_d[1]    = id_is_load;
            unique case (state_q)
                StRun: begin
                    if (redirect && (BUBBLES > 0)) begin
                        state_d = StRedir;
                        cnt_d   = 2'(BUBBLES);
                    end
                end
                StRedir: begin
                    if (cnt_q <= 2'd1) begin
                        state_d = StRun;
                        cnt_d   = 2'd0;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
                default: begin
                    state_d = StRun;
                    cnt_d   = 2'd0;
                end
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StRun;
            cnt_q   <= 2'd0;
            vld_q   <= '0;
            waddr_q <= '0;
            ld_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            waddr_q <= waddr_d;
            ld_q    <= ld_d;
        end
    end

endmodule
